redundancy_expander: RTL and testbench

REDUNDANCY_EXPANDER -- requirements
Module: redundancy_expander

---
 rtl/redundancy_expander_pkg.sv | 14 +
 rtl/redundancy_scatter_slice.sv | 31 +++
 rtl/redundancy_expander.sv | 146 ++++++++++++++
 tb/tb_redundancy_expander.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/redundancy_expander_pkg.sv
// Shared constants and FSM encoding for the redundancy expander.
package redundancy_expander_pkg;

    localparam int unsigned LINE_SIZE      = 128;
    localparam int unsigned CNT_WIDTH      = 8;
    localparam int unsigned LANE_IDX_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCATTER = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/redundancy_scatter_slice.sv
// One compressed slot: decodes its mapping entries into a 128-lane hit vector.
module redundancy_scatter_slice
    import redundancy_expander_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH    = 7,
    parameter int unsigned DIST_WIDTH    = 7,
    parameter int unsigned MAX_LIFM_RSIZ = 4
) (
    input  logic                                en,
    input  logic [PSUM_WIDTH-1:0]               psum,
    input  logic [DIST_WIDTH*MAX_LIFM_RSIZ-1:0] map,
    output logic [LINE_SIZE-1:0]                hit_c,
    output logic [PSUM_WIDTH-1:0]               lane_psum_c
);

    // Any entry naming lane j marks it; duplicate entries collapse to one hit.
    always_comb begin
        hit_c = '0;
        for (int j = 0; j < LINE_SIZE; j++) begin
            for (int r = 0; r < MAX_LIFM_RSIZ; r++) begin
                if (en && (map[r*DIST_WIDTH +: DIST_WIDTH] == DIST_WIDTH'(j))) begin
                    hit_c[j] = 1'b1;
                end
            end
        end
    end

    // The psum travels with the hit vector to the lane merge.
    assign lane_psum_c = psum;

endmodule

// File: rtl/redundancy_expander.sv
// Expands a compressed psum line into 128 lanes using a per-slot mapping table.
module redundancy_expander
    import redundancy_expander_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH      = 7,
    parameter int unsigned DIST_WIDTH      = 7,
    parameter int unsigned MAX_LIFM_RSIZ   = 4,
    parameter int unsigned SLOTS_PER_CYCLE = 8
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [LINE_SIZE*PSUM_WIDTH-1:0]               psum_comp,
    input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp,
    input  logic [CNT_WIDTH-1:0]                          comp_cnt,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [LINE_SIZE*PSUM_WIDTH-1:0]               psum_line,
    output logic [LINE_SIZE-1:0]                          lane_mask
);

    localparam int unsigned MAP_W = DIST_WIDTH * MAX_LIFM_RSIZ;
    localparam int unsigned SUM_W = CNT_WIDTH + 1;

    state_t state;
    state_t next_state;
    logic   accept;
    logic   last_cycle;

    logic [CNT_WIDTH-1:0]  ptr;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [PSUM_WIDTH-1:0] psum_mem [LINE_SIZE];
    logic [MAP_W-1:0]      map_mem  [LINE_SIZE];

    logic [CNT_WIDTH-1:0]  slot_idx  [SLOTS_PER_CYCLE];
    logic                  slot_en   [SLOTS_PER_CYCLE];
    logic [LINE_SIZE-1:0]  slot_hit  [SLOTS_PER_CYCLE];
    logic [PSUM_WIDTH-1:0] slot_psum [SLOTS_PER_CYCLE];

    logic [LINE_SIZE*PSUM_WIDTH-1:0] line_nxt;
    logic [LANE_IDX_WIDTH*0+LINE_SIZE-1:0] mask_nxt;

    assign accept     = in_valid && in_ready;
    assign last_cycle = (SUM_W'(ptr) + SUM_W'(SLOTS_PER_CYCLE)) >= SUM_W'(cnt_q);

    // Slots ptr..ptr+SLOTS_PER_CYCLE-1, each enabled only while below the stored count.
    for (genvar k = 0; k < SLOTS_PER_CYCLE; k++) begin : g_slot
        assign slot_idx[k] = ptr + CNT_WIDTH'(k);
        assign slot_en[k]  = (state == ST_SCATTER) && (slot_idx[k] < cnt_q);

        redundancy_scatter_slice #(
            .PSUM_WIDTH    (PSUM_WIDTH),
            .DIST_WIDTH    (DIST_WIDTH),
            .MAX_LIFM_RSIZ (MAX_LIFM_RSIZ)
        ) u_slice (
            .en          (slot_en[k]),
            .psum        (psum_mem[slot_idx[k][LANE_IDX_WIDTH-1:0]]),
            .map         (map_mem[slot_idx[k][LANE_IDX_WIDTH-1:0]]),
            .hit_c       (slot_hit[k]),
            .lane_psum_c (slot_psum[k])
        );
    end

    // Merge slot hits onto the current line; later (higher) slots override earlier ones.
    always_comb begin
        line_nxt = psum_line;
        mask_nxt = lane_mask;
        for (int k = 0; k < SLOTS_PER_CYCLE; k++) begin
            for (int j = 0; j < LINE_SIZE; j++) begin
                if (slot_hit[k][j]) begin
                    line_nxt[j*PSUM_WIDTH +: PSUM_WIDTH] = slot_psum[k];
                    mask_nxt[j]                          = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = (comp_cnt == '0) ? ST_HOLD : ST_SCATTER;
                end
            end
            ST_SCATTER: begin
                if (last_cycle) begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_valid && out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Captured compressed line; only the accept cycle loads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < LINE_SIZE; i++) begin
                psum_mem[i] <= psum_comp[i*PSUM_WIDTH +: PSUM_WIDTH];
                map_mem[i]  <= mt_comp[i*MAP_W +: MAP_W];
            end
        end
    end

    // Handshake flags, slot pointer, count and the expanded output line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            psum_line <= '0;
            lane_mask <= '0;
            ptr       <= '0;
            cnt_q     <= '0;
        end else begin
            in_ready  <= (next_state == ST_IDLE);
            out_valid <= (next_state == ST_HOLD);
            if (accept) begin
                psum_line <= '0;
                lane_mask <= '0;
                ptr       <= '0;
                cnt_q     <= (comp_cnt > CNT_WIDTH'(LINE_SIZE)) ? CNT_WIDTH'(LINE_SIZE) : comp_cnt;
            end else if (state == ST_SCATTER) begin
                psum_line <= line_nxt;
                lane_mask <= mask_nxt;
                ptr       <= ptr + CNT_WIDTH'(SLOTS_PER_CYCLE);
            end
        end
    end

endmodule

// File: tb/tb_redundancy_expander.sv
// Scoreboard bench for redundancy_expander: reference scatter model vs DUT output lines.
module tb_redundancy_expander;

    localparam int PW  = 7;
    localparam int DW  = 7;
    localparam int R   = 4;
    localparam int SPC = 8;
    localparam int LW  = 128 * PW;
    localparam int MW  = 128 * DW * R;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] psum_comp;
    logic [MW-1:0] mt_comp;
    logic [7:0]    comp_cnt;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] psum_line;
    logic [127:0]  lane_mask;

    typedef struct {
        logic [LW-1:0] line;
        logic [127:0]  mask;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   failures;

    logic [6:0] psum_v [128];
    logic [6:0] map_v  [128][R];

    redundancy_expander #(
        .PSUM_WIDTH      (PW),
        .DIST_WIDTH      (DW),
        .MAX_LIFM_RSIZ   (R),
        .SLOTS_PER_CYCLE (SPC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .psum_comp (psum_comp),
        .mt_comp   (mt_comp),
        .comp_cnt  (comp_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .psum_line (psum_line),
        .lane_mask (lane_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill_random();
        for (int i = 0; i < 128; i++) begin
            psum_v[i] = 7'($urandom);
            for (int r = 0; r < R; r++) map_v[i][r] = 7'($urandom);
        end
    endtask

    task automatic pack_inputs(input int cnt);
        for (int i = 0; i < 128; i++) begin
            psum_comp[i*PW +: PW] = psum_v[i];
            for (int r = 0; r < R; r++) mt_comp[(i*R+r)*DW +: DW] = map_v[i][r];
        end
        comp_cnt = 8'(cnt);
    endtask

    task automatic scramble();
        for (int i = 0; i < 128; i++) begin
            psum_comp[i*PW +: PW] = 7'($urandom);
            for (int r = 0; r < R; r++) mt_comp[(i*R+r)*DW +: DW] = 7'($urandom);
        end
        comp_cnt = 8'($urandom);
    endtask

    // Reference: slots written in ascending order, so later slots overwrite earlier ones.
    task automatic push_expected(input int cnt);
        exp_t e;
        int   n;
        n      = (cnt > 128) ? 128 : cnt;
        e.line = '0;
        e.mask = '0;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < R; r++) begin
                e.line[int'(map_v[i][r])*PW +: PW] = psum_v[i];
                e.mask[map_v[i][r]]                = 1'b1;
            end
        end
        e.lat = (n == 0) ? 1 : ((n + SPC - 1) / SPC) + 1;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int b;
        b = 0;
        while (!in_ready && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL %s ready_timeout: in_ready=%0b required 1", name, in_ready);
        end
    endtask

    // Offer one line, wait for it, compare against the scoreboard; optionally stall the consumer.
    task automatic run_line(input string name, input int cnt, input int hold);
        exp_t e;
        int   lat;
        push_expected(cnt);
        pack_inputs(cnt);
        wait_ready(name);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        scramble();
        out_ready = (hold == 0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
        end
        checks++;
        if (psum_line !== e.line) begin
            failures++;
            $display("FAIL %s psum_line: got %h required %h", name, psum_line, e.line);
        end
        checks++;
        if (lane_mask !== e.mask) begin
            failures++;
            $display("FAIL %s lane_mask: got %h required %h", name, lane_mask, e.mask);
        end
        for (int c = 0; c < hold; c++) begin
            in_valid = c[0];
            scramble();
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || psum_line !== e.line || lane_mask !== e.mask) begin
                failures++;
                $display("FAIL %s hold_stable cycle %0d: out_valid=%0b in_ready=%0b mask=%h required 1 0 %h",
                         name, c, out_valid, in_ready, lane_mask, e.mask);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL %s release: out_valid=%0b in_ready=%0b required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset in_ready: got %0b required 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset out_valid: got %0b required 0", out_valid);
        end
        checks++;
        if (lane_mask !== '0) begin
            failures++;
            $display("FAIL reset lane_mask: got %h required 0", lane_mask);
        end
        checks++;
        if (psum_line !== '0) begin
            failures++;
            $display("FAIL reset psum_line: got %h required 0", psum_line);
        end
    endtask

    task automatic test_basic();
        fill_random();
        psum_v[0] = 7'd5; map_v[0][0] = 7'd0;   map_v[0][1] = 7'd1;   map_v[0][2] = 7'd1;   map_v[0][3] = 7'd1;
        psum_v[1] = 7'd9; map_v[1][0] = 7'd2;   map_v[1][1] = 7'd2;   map_v[1][2] = 7'd2;   map_v[1][3] = 7'd2;
        psum_v[2] = 7'd7; map_v[2][0] = 7'd127; map_v[2][1] = 7'd127; map_v[2][2] = 7'd127; map_v[2][3] = 7'd127;
        run_line("basic3", 3, 0);
    endtask

    task automatic test_zero();
        fill_random();
        run_line("zero", 0, 0);
    endtask

    task automatic test_full();
        for (int i = 0; i < 128; i++) begin
            psum_v[i] = 7'(i);
            for (int r = 0; r < R; r++) map_v[i][r] = 7'(127 - i);
        end
        run_line("full128", 128, 0);
        run_line("clamp200", 200, 0);
    endtask

    task automatic test_conflict();
        fill_random();
        for (int i = 0; i < 13; i++)
            for (int r = 0; r < R; r++) map_v[i][r] = 7'(20 + i);
        psum_v[3]  = 7'd1; map_v[3][2]  = 7'd4;
        psum_v[12] = 7'd2; map_v[12][0] = 7'd4;
        run_line("conflict_cross", 13, 0);
        fill_random();
        for (int i = 0; i < 7; i++)
            for (int r = 0; r < R; r++) map_v[i][r] = 7'(50 + i);
        psum_v[1] = 7'd11; map_v[1][3] = 7'd4;
        psum_v[6] = 7'd22; map_v[6][1] = 7'd4;
        run_line("conflict_within", 7, 0);
    endtask

    task automatic test_hold();
        fill_random();
        run_line("hold10", 20, 10);
        fill_random();
        run_line("after_hold", 9, 0);
    endtask

    task automatic test_mid_reset();
        int pulses;
        fill_random();
        pack_inputs(128);
        wait_ready("mid_reset");
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10 || lane_mask !== '0) begin
            failures++;
            $display("FAIL mid_reset state: in_ready=%0b out_valid=%0b mask=%h required 1 0 0",
                     in_ready, out_valid, lane_mask);
        end
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL mid_reset no_pulse: got %0d out_valid cycles required 0", pulses);
        end
        fill_random();
        run_line("post_reset", 37, 0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            fill_random();
            run_line($sformatf("random%0d", t), int'($urandom_range(0, 128)), 0);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        psum_comp = '0;
        mt_comp   = '0;
        comp_cnt  = '0;
        test_reset();
        test_basic();
        test_zero();
        test_full();
        test_conflict();
        test_hold();
        test_mid_reset();
        test_random();
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
